// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus definitions: memory map, target select encodings and arbiter FSM states.
package dbus_arbiter_pkg;

  // RAM occupies the bottom half of the space starting at address 0.
  localparam logic [31:0] RAM_LIMIT  = 32'h7FFF_FFFF;
  localparam logic [31:0] GPIO_ADDR  = 32'h8000_0000;
  localparam logic [31:0] UART_BASE  = 32'h8000_0004;
  localparam logic [31:0] UART_LIMIT = 32'h8000_000F;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_RAM  = 2'd0;
  localparam sel_t SEL_GPIO = 2'd1;
  localparam sel_t SEL_UART = 2'd2;
  localparam sel_t SEL_NONE = 2'd3;

  typedef enum logic [0:0] {
    StArb,
    StLock
  } arb_state_e;

endpackage

// File: rtl/dbus_arbiter_addr_decode.sv
// Maps a bus address onto its target select; shared with the top-level IO select logic.
module dbus_arbiter_addr_decode
  import dbus_arbiter_pkg::*;
(
  input  logic [31:0] addr,
  output sel_t        sel
);

  always_comb begin
    sel = SEL_NONE;
    if (addr <= RAM_LIMIT) begin
      sel = SEL_RAM;
    end else if (addr == GPIO_ADDR) begin
      sel = SEL_GPIO;
    end else if (addr >= UART_BASE && addr <= UART_LIMIT) begin
      sel = SEL_UART;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: CPU vs. loader, loader priority with starvation guard and
// a lock mode, single-cycle target access with registered read responses.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned LDR_MAX = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  input  logic        ldr_lock,
  output logic        ldr_gnt,
  output logic        ldr_rvalid,
  output logic [31:0] ldr_rdata,
  output logic        tgt_en,
  output logic        tgt_we,
  output logic [1:0]  tgt_sel,
  output logic [31:0] tgt_addr,
  output logic [31:0] tgt_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] gpio_rdata,
  input  logic [31:0] uart_rdata,
  output logic        err
);

  localparam int unsigned CntW = (LDR_MAX < 1) ? 1 : $clog2(LDR_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(LDR_MAX);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic        gnt_any;
  logic        gnt_we;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  sel_t        sel;
  logic [31:0] rd_mux;

  logic        cpu_rvalid_q, ldr_rvalid_q, err_q;
  logic [31:0] cpu_rdata_q, ldr_rdata_q;

  // Grants are gated by reset so every combinational output sits at zero while held in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (reset) begin
      if (state_q == StLock) begin
        ldr_gnt = ldr_req;
      end else if (cpu_req && ldr_req) begin
        if (starve_q == StarveMax) cpu_gnt = 1'b1;
        else                       ldr_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        ldr_gnt = ldr_req;
      end
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_gnt;
  assign gnt_any   = cpu_gnt | ldr_gnt;

  always_comb begin
    gnt_we    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    if (cpu_gnt) begin
      gnt_we    = cpu_we;
      gnt_addr  = cpu_addr;
      gnt_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      gnt_we    = ldr_we;
      gnt_addr  = ldr_addr;
      gnt_wdata = ldr_wdata;
    end
  end

  dbus_arbiter_addr_decode addr_decode (
    .addr (gnt_addr),
    .sel  (sel)
  );

  assign tgt_en    = gnt_any & (sel != SEL_NONE);
  assign tgt_we    = gnt_any & gnt_we;
  assign tgt_sel   = sel;
  assign tgt_addr  = gnt_addr;
  assign tgt_wdata = gnt_wdata;

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      SEL_RAM:  rd_mux = ram_rdata;
      SEL_GPIO: rd_mux = gpio_rdata;
      SEL_UART: rd_mux = uart_rdata;
      SEL_NONE: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d  = ldr_lock ? StLock : StArb;
    starve_d = starve_q;
    if (state_q == StLock || !cpu_req || cpu_gnt) begin
      starve_d = '0;
    end else if (ldr_gnt && starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= StArb;
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      ldr_rvalid_q <= ldr_gnt & ~ldr_we;
      err_q        <= gnt_any & (sel == SEL_NONE);
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= rd_mux;
      if (ldr_gnt && !ldr_we) ldr_rdata_q <= rd_mux;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: inputs change 1ns after the rising edge, outputs are
// checked on the falling edge.
module tb_dbus_arbiter;

  logic        CLK, reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        tgt_en, tgt_we, err;
  logic [1:0]  tgt_sel;
  logic [31:0] tgt_addr, tgt_wdata;
  logic [31:0] ram_rdata, gpio_rdata, uart_rdata;

  int errors = 0;
  int checks = 0;

  // RAM returns a value tied to the address presented, so rdata proves which cycle was sampled.
  assign ram_rdata  = tgt_addr ^ 32'hA5A5_0000;
  assign gpio_rdata = 32'h6910_0001;
  assign uart_rdata = 32'hCAFE_0008;

  dbus_arbiter #(.LDR_MAX(4)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_lock   (ldr_lock),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .tgt_en     (tgt_en),
    .tgt_we     (tgt_we),
    .tgt_sel    (tgt_sel),
    .tgt_addr   (tgt_addr),
    .tgt_wdata  (tgt_wdata),
    .ram_rdata  (ram_rdata),
    .gpio_rdata (gpio_rdata),
    .uart_rdata (uart_rdata),
    .err        (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    cpu_req = 1; cpu_addr = 32'h10;
    ldr_req = 1; ldr_addr = 32'h20;
    tick();
    @(negedge CLK);
    checks++; if (cpu_gnt !== 1'b0 || ldr_gnt !== 1'b0) begin errors++;
      $display("FAIL rst_gnt: got cpu=%b ldr=%b expected 0 0", cpu_gnt, ldr_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++;
      $display("FAIL rst_stall: got %b expected 0", cpu_stall); end
    checks++; if ({tgt_en, tgt_we, tgt_sel, tgt_addr, tgt_wdata} !== 68'd0) begin errors++;
      $display("FAIL rst_tgt: got en=%b we=%b sel=%0d addr=%h wd=%h expected all 0",
               tgt_en, tgt_we, tgt_sel, tgt_addr, tgt_wdata); end
    checks++; if ({cpu_rvalid, ldr_rvalid, err, cpu_rdata, ldr_rdata} !== 67'd0) begin errors++;
      $display("FAIL rst_resp: got rv=%b/%b err=%b rd=%h/%h expected all 0",
               cpu_rvalid, ldr_rvalid, err, cpu_rdata, ldr_rdata); end
    tick();
    reset = 1;
    @(negedge CLK);
    checks++; if (ldr_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++;
      $display("FAIL first_gnt: got cpu=%b ldr=%b expected 0 1", cpu_gnt, ldr_gnt); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_both_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h20;
    @(negedge CLK);
    checks++; if (ldr_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin errors++;
      $display("FAIL both_c0_gnt: got cpu=%b ldr=%b stall=%b expected 0 1 1",
               cpu_gnt, ldr_gnt, cpu_stall); end
    checks++; if (tgt_addr !== 32'h20 || tgt_en !== 1'b1 || tgt_sel !== 2'd0) begin errors++;
      $display("FAIL both_c0_tgt: got addr=%h en=%b sel=%0d expected 00000020 1 0",
               tgt_addr, tgt_en, tgt_sel); end
    tick();
    ldr_req = 0;
    @(negedge CLK);
    checks++; if (cpu_gnt !== 1'b1 || tgt_addr !== 32'h10) begin errors++;
      $display("FAIL both_c1_gnt: got cpu=%b addr=%h expected 1 00000010", cpu_gnt, tgt_addr); end
    checks++; if (ldr_rvalid !== 1'b1 || ldr_rdata !== 32'hA5A5_0020 || cpu_rvalid !== 1'b0)
      begin errors++;
      $display("FAIL both_c1_ldr_resp: got rv=%b rd=%h cpu_rv=%b expected 1 a5a50020 0",
               ldr_rvalid, ldr_rdata, cpu_rvalid); end
    tick();
    cpu_req = 0;
    @(negedge CLK);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5_0010 || ldr_rvalid !== 1'b0)
      begin errors++;
      $display("FAIL both_c2_cpu_resp: got rv=%b rd=%h ldr_rv=%b expected 1 a5a50010 0",
               cpu_rvalid, cpu_rdata, ldr_rvalid); end
    checks++; if (ldr_rdata !== 32'hA5A5_0020) begin errors++;
      $display("FAIL both_hold: got ldr_rdata=%h expected a5a50020", ldr_rdata); end
    tick();
    idle();
  endtask

  task automatic test_starvation();
    int stalls = 0;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h80; ldr_wdata = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (cpu_stall === 1'b1) stalls++;
      checks++; if (ldr_gnt !== (i < 4) || cpu_gnt !== (i == 4)) begin errors++;
        $display("FAIL starve_c%0d: got cpu=%b ldr=%b expected %b %b",
                 i, cpu_gnt, ldr_gnt, i == 4, i < 4); end
      tick();
    end
    cpu_req = 0;
    checks++; if (stalls !== 4) begin errors++;
      $display("FAIL starve_stalls: got %0d cycles expected 4", stalls); end
    @(negedge CLK);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5_0040) begin errors++;
      $display("FAIL starve_resp: got rv=%b rd=%h expected 1 a5a50040", cpu_rvalid, cpu_rdata); end
    tick();
    idle();
  endtask

  task automatic test_lock();
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        ldr_lock = 1; ldr_req = 1; ldr_we = 1; ldr_addr = 32'h100; ldr_wdata = 32'h5;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
      end
      if (i == 10) begin
        ldr_lock = 0; ldr_req = 0;
      end
      @(negedge CLK);
      checks++;
      if (cpu_gnt !== (i == 11) || ldr_gnt !== (i < 10) || cpu_stall !== (i != 11)) begin
        errors++;
        $display("FAIL lock_c%0d: got cpu=%b ldr=%b stall=%b expected %b %b %b",
                 i, cpu_gnt, ldr_gnt, cpu_stall, i == 11, i < 10, i != 11);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_decode();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8000_0000; cpu_wdata = 32'h1234_5678;
    @(negedge CLK);
    checks++; if (cpu_gnt !== 1'b1 || tgt_sel !== 2'd1 || tgt_en !== 1'b1 || tgt_we !== 1'b1
                  || tgt_wdata !== 32'h1234_5678) begin errors++;
      $display("FAIL dec_gpio_wr: got gnt=%b sel=%0d en=%b we=%b wd=%h expected 1 1 1 1 12345678",
               cpu_gnt, tgt_sel, tgt_en, tgt_we, tgt_wdata); end
    tick();
    cpu_we = 0; cpu_addr = 32'h8000_0008;
    @(negedge CLK);
    checks++; if (tgt_sel !== 2'd2 || tgt_en !== 1'b1 || tgt_we !== 1'b0) begin errors++;
      $display("FAIL dec_uart_rd: got sel=%0d en=%b we=%b expected 2 1 0", tgt_sel, tgt_en, tgt_we);
    end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++;
      $display("FAIL write_no_rvalid: got %b expected 0", cpu_rvalid); end
    tick();
    cpu_addr = 32'h9000_0000;
    @(negedge CLK);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFE_0008) begin errors++;
      $display("FAIL uart_resp: got rv=%b rd=%h expected 1 cafe0008", cpu_rvalid, cpu_rdata); end
    checks++; if (tgt_sel !== 2'd3 || tgt_en !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL dec_unmapped: got sel=%0d en=%b err=%b expected 3 0 0", tgt_sel, tgt_en, err);
    end
    tick();
    cpu_req = 0;
    @(negedge CLK);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0 || err !== 1'b1) begin errors++;
      $display("FAIL unmapped_resp: got rv=%b rd=%h err=%b expected 1 00000000 1",
               cpu_rvalid, cpu_rdata, err); end
    tick();
    @(negedge CLK);
    checks++; if (err !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++;
      $display("FAIL err_pulse: got err=%b rv=%b expected 0 0", err, cpu_rvalid); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    @(negedge CLK);
    checks++; if (cpu_gnt !== 1'b1) begin errors++;
      $display("FAIL b2b_gnt: got %b expected 1", cpu_gnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) cpu_addr = 32'h104 + 32'(4 * i);
      else       cpu_req = 0;
      @(negedge CLK);
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== (32'hA5A5_0100 + 32'(4 * i))) begin
        errors++;
        $display("FAIL b2b_resp%0d: got rv=%b rd=%h expected 1 %h",
                 i, cpu_rvalid, cpu_rdata, 32'hA5A5_0100 + 32'(4 * i));
      end
    end
    tick();
    idle();
  endtask

  task automatic test_reset_inflight();
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h30;
    @(negedge CLK);
    checks++; if (ldr_gnt !== 1'b1) begin errors++;
      $display("FAIL inflight_gnt: got %b expected 1", ldr_gnt); end
    #1;
    reset = 0;
    ldr_req = 0;
    cpu_req = 1; cpu_addr = 32'h44;
    tick();
    checks++; if (ldr_rvalid !== 1'b0 || ldr_rdata !== 32'h0) begin errors++;
      $display("FAIL inflight_drop: got rv=%b rd=%h expected 0 00000000", ldr_rvalid, ldr_rdata);
    end
    checks++; if ({cpu_gnt, cpu_stall, tgt_en, err, cpu_rdata, tgt_addr} !== 68'd0) begin errors++;
      $display("FAIL inflight_rst_out: got gnt=%b stall=%b en=%b err=%b rd=%h addr=%h expected 0",
               cpu_gnt, cpu_stall, tgt_en, err, cpu_rdata, tgt_addr); end
    reset = 1;
    @(negedge CLK);
    checks++; if (cpu_gnt !== 1'b1 || ldr_rvalid !== 1'b0) begin errors++;
      $display("FAIL post_rst_gnt: got gnt=%b ldr_rv=%b expected 1 0", cpu_gnt, ldr_rvalid); end
    tick();
    cpu_req = 0;
    @(negedge CLK);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5_0044 || ldr_rvalid !== 1'b0)
      begin errors++;
      $display("FAIL post_rst_resp: got rv=%b rd=%h ldr_rv=%b expected 1 a5a50044 0",
               cpu_rvalid, cpu_rdata, ldr_rvalid); end
    tick();
    idle();
  endtask

  initial begin
    reset = 0;
    idle();
    test_reset();
    test_both_read();
    test_starvation();
    test_lock();
    test_decode();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
